shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 a  input  WIDTH  multiplier.
REQ-006 b  input  WIDTH  multiplicand.
REQ-007 busy  output  1  high while in CALC.
REQ-008 done  output  1  one-cycle pulse; p holds a new result.
REQ-009 p  output  2*WIDTH  product register.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-011 IDLE/DONE with start=1: at the edge, latch a into the multiplier shift register and b zero-extended to 2*WIDTH into the multiplicand register, clear the internal accumulator and bit counter, and go to CALC.
REQ-012 IDLE with start=0 SHALL stay in IDLE; DONE with start=0 SHALL go to IDLE.
REQ-013 Each CALC edge: if the multiplier LSB is 1, add the multiplicand to the accumulator (mod 2^(2*WIDTH)); shift the multiplier right 1, the multiplicand left 1, and increment the counter.
REQ-014 After exactly WIDTH CALC edges, go to DONE and write the final accumulator value to p at that same edge.
REQ-015 Latency: start accepted at edge E0 -> done=1 and p valid in the cycle after edge E0+WIDTH.
REQ-016 done SHALL be 1 only in DONE; busy SHALL be 1 only in CALC; they are never high together.
REQ-017 p SHALL change only when entering DONE and holds its value through IDLE and any following CALC until the next DONE.
REQ-018 start during CALC SHALL be ignored; a, b changes during CALC SHALL NOT affect the result.
REQ-019 start in DONE SHALL begin a new operation back-to-back, with no IDLE cycle.
REQ-020 Unsigned result SHALL equal a*b exactly (no overflow is possible in 2*WIDTH bits).

Reset
REQ-021 rst=1 at an edge SHALL force IDLE, p=0, busy=0, done=0, and clear the accumulator, counter and operand registers; it overrides start.
REQ-022 rst asserted during CALC SHALL abort the operation; no done pulse SHALL follow, and p SHALL read 0.

Configuration
REQ-023 Macro SHIFT_ADD_MULT_SIGNED_EN SHALL control signed support.
REQ-024 With the macro defined: add input port is_signed (1 bit), sampled together with start; when it is 1, b is sign-extended to 2*WIDTH, the partial product of a's MSB is subtracted rather than added, and p = signed(a)*signed(b) in two's complement.
REQ-025 With the macro defined and is_signed=0, behaviour SHALL be identical to the unsigned build.
REQ-026 Without the macro: the is_signed port is absent, and operation is unsigned only, with unchanged latency.
REQ-027 Latency and handshake SHALL be identical in both builds.

Verification (WIDTH=4)
REQ-028 Start with a=3, b=5 -> busy for 4 cycles, then done pulse, p=0x0F; p holds 0x0F afterwards.
REQ-029 a=15, b=15, then start again in DONE with a=0, b=9 -> p=0xE1, then p=0x00 exactly 4 cycles later; no IDLE gap.
REQ-030 Start with a=2, b=3; pulse start and change a, b during CALC -> p=0x06; the extra start is ignored.
REQ-031 Assert rst in the 2nd CALC cycle of a=7, b=7 -> IDLE, p=0, no done pulse; the next op a=1, b=1 gives p=0x01.
REQ-032 SIGNED_EN build, is_signed=1: a=-8, b=-8 -> p=0x40; a=-1, b=7 -> p=0xF9; with is_signed=0, a=0xF, b=0x7 -> p=0x69.

Source files
------------

// File: rtl/shift_add_mult.sv
// ============================================================================
// Module   : shift_add_mult
// Purpose  : Sequential shift-and-add multiplier using one adder. It retires
//            one multiplier bit per clock and keeps its result in a register.
//            Define SHIFT_ADD_MULT_SIGNED_EN to add the is_signed input, which
//            selects two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    input  logic                 is_signed,
`endif
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int c_PW = 2 * WIDTH;
    localparam int c_CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [WIDTH-1:0]  r_mplr;
    logic [c_PW-1:0]   r_mcand;
    logic [c_PW-1:0]   r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic [c_PW-1:0]   r_p;
    logic              r_signed;

    logic              w_is_signed;
    logic              w_accept;
    logic              w_last;
    logic              w_sub;
    logic [c_PW-1:0]   w_b_ext;
    logic [c_PW-1:0]   w_term;
    logic [c_PW-1:0]   w_acc_next;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    assign w_is_signed = is_signed;
`else
    assign w_is_signed = 1'b0;
`endif

    assign w_accept   = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last     = (r_state == c_CALC) && (r_cnt == c_LAST);
    assign w_b_ext    = {{WIDTH{w_is_signed & b[WIDTH-1]}}, b};
    // The final step consumes the multiplier MSB, whose weight is negative
    // for two's-complement operands.
    assign w_sub      = r_signed && w_last;
    assign w_term     = r_mplr[0] ? r_mcand : '0;
    assign w_acc_next = w_sub ? (r_acc - w_term) : (r_acc + w_term);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  w_next = start ? c_CALC : c_IDLE;
            c_CALC:  w_next = w_last ? c_DONE : c_CALC;
            c_DONE:  w_next = start ? c_CALC : c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_CALC);
        done = (r_state == c_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mplr   <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_mplr   <= a;
            r_mcand  <= w_b_ext;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_signed <= w_is_signed;
        end else if (r_state == c_CALC) begin
            r_acc   <= w_acc_next;
            r_mplr  <= r_mplr >> 1;
            r_mcand <= r_mcand << 1;
            r_cnt   <= r_cnt + c_ONE;
            if (w_last) begin
                r_p <= w_acc_next;
            end
        end
    end

    assign p = r_p;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult.sv
// ============================================================================
// Module   : tb_shift_add_mult
// Purpose  : Directed self-checking bench for shift_add_mult (WIDTH=4) that
//            compares the DUT against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_mult;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           is_signed = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int errors = 0;
    int checks = 0;

    shift_add_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        .is_signed (is_signed),
`endif
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .p         (p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a busy window of W cycles after an accepted start,
    // then one DONE cycle carrying the arithmetic product.
    logic           m_valid = 1'b0;
    logic           m_busy  = 1'b0;
    logic           m_done  = 1'b0;
    int             m_left  = 0;
    logic [2*W-1:0] m_res   = '0;
    logic [2*W-1:0] m_p     = '0;
    logic [2*W-1:0] m_ae, m_be;
    logic           m_sgn;

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_p    = '0;
        end else if (!m_busy && start) begin
`ifdef SHIFT_ADD_MULT_SIGNED_EN
            m_sgn = is_signed;
`else
            m_sgn = 1'b0;
`endif
            m_ae   = {{W{m_sgn & a[W-1]}}, a};
            m_be   = {{W{m_sgn & b[W-1]}}, b};
            m_res  = m_ae * m_be;
            m_busy = 1'b1;
            m_done = 1'b0;
            m_left = W;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_p    = m_res;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("p", p, m_p);
            if (busy && done) chk("busy_and_done", 1'b1, 1'b0);
        end
    end

    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg);
        a = av;
        b = bv;
        is_signed = sg;
        start = 1'b1;
    endtask

    // Counts negedges from the launch until done is seen.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!done && n < 20);
        if (!done) chk("done_timeout", 1'b0, 1'b1);
    endtask

    int n;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_p", p, 8'h00);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 3 x 5
        launch(4'd3, 4'd5, 1'b0);
        wait_done(n);
        chk("lat_3x5", n, W + 1);
        chk("p_3x5", p, 8'h0F);
        chk("model_3x5", m_p, 8'h0F);
        repeat (3) @(negedge clk);
        chk("hold_3x5", p, 8'h0F);

        // 15 x 15, then back-to-back 0 x 9 from DONE
        launch(4'd15, 4'd15, 1'b0);
        wait_done(n);
        chk("p_15x15", p, 8'hE1);
        launch(4'd0, 4'd9, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_hold", p, 8'hE1);
        wait_done(n);
        chk("lat_b2b", n, W);
        chk("p_0x9", p, 8'h00);

        // extra start and operand changes during CALC are ignored
        @(negedge clk);
        launch(4'd2, 4'd3, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        launch(4'd9, 4'd7, 1'b0);
        wait_done(n);
        chk("lat_ign", n, W - 1);
        chk("p_2x3", p, 8'h06);
        @(negedge clk);
        chk("no_restart", busy, 1'b0);

        // reset in the 2nd CALC cycle aborts
        launch(4'd7, 4'd7, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_p", p, 8'h00);
        chk("abort_busy", busy, 1'b0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        launch(4'd1, 4'd1, 1'b0);
        wait_done(n);
        chk("p_1x1", p, 8'h01);

        // a few more patterns, including operand extremes
        launch(4'd10, 4'd12, 1'b0); wait_done(n); chk("p_10x12", p, 8'h78);
        launch(4'd8,  4'd15, 1'b0); wait_done(n); chk("p_8x15", p, 8'h78);
        launch(4'd15, 4'd0,  1'b0); wait_done(n); chk("p_15x0", p, 8'h00);
        launch(4'd15, 4'd1,  1'b0); wait_done(n); chk("p_15x1", p, 8'h0F);

`ifdef SHIFT_ADD_MULT_SIGNED_EN
        launch(4'h8, 4'h8, 1'b1); wait_done(n); chk("s_m8xm8", p, 8'h40);
        launch(4'hF, 4'h7, 1'b1); wait_done(n); chk("s_m1x7", p, 8'hF9);
        launch(4'hF, 4'h7, 1'b0); wait_done(n); chk("u_15x7", p, 8'h69);
        launch(4'h7, 4'h9, 1'b1); wait_done(n); chk("s_7xm7", p, 8'hCF);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
